// File: rtl/fifo_120_48_pkg.sv
// Shared defaults for the fifo_120_48 FIFO.
// FIFO_120_48_SHOWAHEAD_EN selects show-ahead read behaviour.
package fifo_120_48_pkg;

    localparam int unsigned FIFO_WIDTH = 16;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned FIFO_AW    = $clog2(FIFO_DEPTH);

endpackage

// File: rtl/fifo_120_48_ram.sv
// Simple dual-port storage for fifo_120_48: synchronous write port plus a read port.
// The read port is registered by default and becomes a lookahead read under FIFO_120_48_SHOWAHEAD_EN.
module fifo_120_48_ram
    import fifo_120_48_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH,
    parameter int unsigned DEPTH = FIFO_DEPTH,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

`ifdef FIFO_120_48_SHOWAHEAD_EN
    // Caller registers the word itself; reset and read-enable are not needed here.
    logic unused_ctrl;
    assign unused_ctrl = rst_i ^ rd_en_i;
    assign rd_data_o   = mem[rd_addr_i];
`else
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;
`endif

endmodule

// File: rtl/fifo_120_48.sv
// Single-clock 16-bit FIFO with full/empty flags and a registered fill count.
// Define FIFO_120_48_SHOWAHEAD_EN for show-ahead output; default is registered normal-mode read.
module fifo_120_48
    import fifo_120_48_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH,
    parameter int unsigned DEPTH = FIFO_DEPTH,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic [WIDTH-1:0] data,
    input  logic             wrreq,
    input  logic             rdreq,
    output logic [WIDTH-1:0] q,
    output logic             rdempty,
    output logic             wrfull,
    output logic [AW:0]      usedw
);

    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [AW:0]      usedw_q, usedw_d;
    logic             wr_acc, rd_acc;
    logic [AW-1:0]    ram_rd_addr;
    logic [WIDTH-1:0] ram_rd_data;

    assign rdempty = (usedw_q == '0);
    assign wrfull  = (usedw_q == (AW+1)'(DEPTH));
    assign usedw   = usedw_q;

    always_comb begin
        wr_acc  = wrreq & ~wrfull;
        rd_acc  = rdreq & ~rdempty;
        wp_d    = wr_acc ? wp_q + AW'(1) : wp_q;
        rp_d    = rd_acc ? rp_q + AW'(1) : rp_q;
        usedw_d = usedw_q;
        if (wr_acc && !rd_acc) begin
            usedw_d = usedw_q + (AW+1)'(1);
        end else if (rd_acc && !wr_acc) begin
            usedw_d = usedw_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            wp_q    <= '0;
            rp_q    <= '0;
            usedw_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            usedw_q <= usedw_d;
        end
    end

`ifdef FIFO_120_48_SHOWAHEAD_EN
    // Lookahead address fetches the word that becomes oldest once the current one is read.
    assign ram_rd_addr = rp_q + AW'(1);
`else
    assign ram_rd_addr = rp_q;
`endif

    fifo_120_48_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i     (clock),
        .rst_i     (aclr),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wp_q),
        .wr_data_i (data),
        .rd_en_i   (rd_acc),
        .rd_addr_i (ram_rd_addr),
        .rd_data_o (ram_rd_data)
    );

`ifdef FIFO_120_48_SHOWAHEAD_EN
    logic [WIDTH-1:0] q_q, q_d;

    // Next head is the lookahead word, or the incoming word when only one remains.
    always_comb begin
        q_d = q_q;
        if (wr_acc && usedw_q == '0) begin
            q_d = data;
        end else if (rd_acc) begin
            if (usedw_q > (AW+1)'(1)) begin
                q_d = ram_rd_data;
            end else if (wr_acc) begin
                q_d = data;
            end
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
`else
    assign q = ram_rd_data;
`endif

endmodule

// File: tb/tb_fifo_120_48.sv
// Directed self-checking bench for fifo_120_48 in its default (normal read) build.
module tb_fifo_120_48;

    logic        clock;
    logic        aclr;
    logic [15:0] data;
    logic        wrreq;
    logic        rdreq;
    logic [15:0] q;
    logic        rdempty;
    logic        wrfull;
    logic [4:0]  usedw;

    int unsigned checks;
    int unsigned errors;

    logic [15:0] sb [$];
    logic [15:0] exp_q;
    logic [15:0] next_w;
    logic        wr_acc;
    logic        rd_acc;

    fifo_120_48 #(
        .WIDTH (16),
        .DEPTH (16)
    ) dut (
        .clock   (clock),
        .aclr    (aclr),
        .data    (data),
        .wrreq   (wrreq),
        .rdreq   (rdreq),
        .q       (q),
        .rdempty (rdempty),
        .wrfull  (wrfull),
        .usedw   (usedw)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        aclr   = 1'b1;
        data   = '0;
        wrreq  = 1'b0;
        rdreq  = 1'b0;

        // Reset held and released
        repeat (2) @(posedge clock);
        #1;
        check("rst_empty", 32'(rdempty), 32'd1);
        check("rst_full",  32'(wrfull),  32'd0);
        check("rst_usedw", 32'(usedw),   32'd0);
        check("rst_q",     32'(q),       32'd0);
        aclr = 1'b0;
        step();
        check("rel_empty", 32'(rdempty), 32'd1);
        check("rel_usedw", 32'(usedw),   32'd0);

        // Single word
        data = 16'h1234; wrreq = 1'b1;
        step();
        wrreq = 1'b0;
        check("sw_empty", 32'(rdempty), 32'd0);
        check("sw_usedw", 32'(usedw),   32'd1);
        rdreq = 1'b1;
        step();
        rdreq = 1'b0;
        check("sw_q",      32'(q),       32'h1234);
        check("sw_usedw0", 32'(usedw),   32'd0);
        check("sw_empty1", 32'(rdempty), 32'd1);

        // Fill to full
        for (int i = 0; i < 16; i++) begin
            data = 16'(i); wrreq = 1'b1;
            step();
        end
        check("fill_full",  32'(wrfull), 32'd1);
        check("fill_usedw", 32'(usedw),  32'd16);
        data = 16'h0010;
        step();
        check("ovf_usedw", 32'(usedw), 32'd16);
        // Write while full alongside an accepted read: write must still be dropped
        rdreq = 1'b1;
        step();
        wrreq = 1'b0;
        check("ovfrd_q",     32'(q),      32'h0000);
        check("ovfrd_usedw", 32'(usedw),  32'd15);
        check("ovfrd_full",  32'(wrfull), 32'd0);
        for (int i = 1; i < 16; i++) begin
            step();
            check("drain_q", 32'(q), 32'(i));
        end
        rdreq = 1'b0;
        check("drain_empty", 32'(rdempty), 32'd1);
        check("drain_usedw", 32'(usedw),   32'd0);

        // Underflow
        rdreq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("udf_q",     32'(q),     32'h000F);
            check("udf_usedw", 32'(usedw), 32'd0);
        end
        rdreq = 1'b0;

        // Simultaneous read/write at depth 4 across pointer wrap
        for (int i = 0; i < 4; i++) begin
            data = 16'(100 + i); wrreq = 1'b1;
            step();
        end
        check("sim_pre_usedw", 32'(usedw), 32'd4);
        rdreq = 1'b1;
        for (int k = 0; k < 20; k++) begin
            data = 16'(104 + k);
            step();
            check("sim_q",     32'(q),     32'(100 + k));
            check("sim_usedw", 32'(usedw), 32'd4);
        end
        wrreq = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("sim_drain_q", 32'(q), 32'(120 + k));
        end
        rdreq = 1'b0;
        check("sim_empty", 32'(rdempty), 32'd1);

        // Asynchronous clear mid-stream
        for (int i = 0; i < 5; i++) begin
            data = 16'(16'hA0 + i); wrreq = 1'b1;
            step();
        end
        wrreq = 1'b0;
        check("aclr_pre_usedw", 32'(usedw), 32'd5);
        #2;
        aclr = 1'b1;
        #1;
        check("aclr_usedw", 32'(usedw),   32'd0);
        check("aclr_empty", 32'(rdempty), 32'd1);
        check("aclr_full",  32'(wrfull),  32'd0);
        check("aclr_q",     32'(q),       32'd0);
        #1;
        aclr = 1'b0;
        step();

        // Write and read together while empty: only the write is taken
        data = 16'h55AA; wrreq = 1'b1; rdreq = 1'b1;
        step();
        wrreq = 1'b0;
        check("ewr_usedw", 32'(usedw), 32'd1);
        check("ewr_q",     32'(q),     32'd0);
        step();
        rdreq = 1'b0;
        check("ewr_rd_q",     32'(q),     32'h55AA);
        check("ewr_rd_usedw", 32'(usedw), 32'd0);

        // Rate mismatch: write 1 in 4 cycles, read 1 in 6
        next_w = 16'h0200;
        exp_q  = q;
        for (int c = 0; c < 200; c++) begin
            wrreq  = (c % 4 == 0);
            rdreq  = (c % 6 == 0);
            data   = next_w;
            wr_acc = wrreq && (sb.size() < 16);
            rd_acc = rdreq && (sb.size() > 0);
            if (rd_acc) exp_q = sb.pop_front();
            if (wr_acc) begin
                sb.push_back(next_w);
                next_w = next_w + 16'd1;
            end
            step();
            check("rate_q",     32'(q),     32'(exp_q));
            check("rate_usedw", 32'(usedw), 32'(sb.size()));
        end
        wrreq = 1'b0;
        rdreq = 1'b0;
        check("rate_full", 32'(wrfull), 32'(sb.size() == 16));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
